// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: bus widths that the PC register and IF/ID latch also use, the IF state
// encodings, and a helper that places one fetched byte into a little-endian word.
package if_fetch_pkg;

  localparam int INST_W     = 32;  // instruction bus width
  localparam int ADDR_BUS_W = 32;  // architectural pc width
  localparam int BYTE_W     = 8;   // shared RAM port data width

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

  // Place byte b into lane k (bits [8k+7:8k]) of a little-endian word.
  function automatic logic [INST_W-1:0] place_byte(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        k,
                                                   input logic [BYTE_W-1:0] b);
    logic [INST_W-1:0] w;
    w = word;
    case (k)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Ports:
//   clk, rst        clock; synchronous active-high reset clears every valid bit
//   rd_waddr_i      word address of the lookup (byte address without bits [1:0])
//   rd_hit_o        combinational: line valid and tag matches
//   rd_data_o       combinational: data word of the indexed line
//   wr_en_i         write one line (sets its valid bit)
//   wr_waddr_i      word address of the line being written
//   wr_data_i       word written into the line
// A lookup in the same cycle as a write to the same index sees the old contents,
// because all arrays are registers updated at the edge.
module icache_dm
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int IC_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-3:0] rd_waddr_i,
  output logic              rd_hit_o,
  output logic [INST_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-3:0] wr_waddr_i,
  input  logic [INST_W-1:0] wr_data_i
);

  localparam int IDX_W = $clog2(IC_LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [IC_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [IC_LINES];
  logic [INST_W-1:0]   data_q [IC_LINES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_waddr_i[IDX_W-1:0];
  assign rd_tag = rd_waddr_i[ADDR_W-3:IDX_W];
  assign wr_idx = wr_waddr_i[IDX_W-1:0];
  assign wr_tag = wr_waddr_i[ADDR_W-3:IDX_W];

  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage between the PC register and the IF/ID latch.
// Hits in the direct-mapped I-cache return the instruction one cycle later with no
// stall; misses are filled byte-serially over the shared 8-bit RAM port while
// stall_req_o holds the PC register.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   pc_i, ce_i         fetch address (word aligned) and fetch enable
//   branch_i           redirect from EX: abandon the current fetch
//   id_stall_i         downstream stall: IF/ID outputs hold
//   mem_req_o          request for the shared RAM port (registered)
//   mem_grant_i        arbiter grant for this cycle
//   mem_addr_o         byte address, meaningful when mem_req_o && mem_grant_i
//   mem_data_i         read byte, one cycle after each granted address
//   stall_req_o        combinational PC-hold request
//   inst_o, inst_pc_o  fetched instruction and its pc
//   inst_valid_o       0 marks a bubble
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int IC_LINES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BUS_W-1:0] pc_i,
  input  logic                  ce_i,
  input  logic                  branch_i,
  input  logic                  id_stall_i,
  output logic                  mem_req_o,
  input  logic                  mem_grant_i,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [BYTE_W-1:0]     mem_data_i,
  output logic                  stall_req_o,
  output logic [INST_W-1:0]     inst_o,
  output logic [ADDR_BUS_W-1:0] inst_pc_o,
  output logic                  inst_valid_o
);

  if_state_e             state_q, state_d;
  logic [ADDR_BUS_W-1:0] fpc_q, fpc_d;
  logic [1:0]            issue_cnt_q, issue_cnt_d;
  logic [1:0]            rx_cnt_q, rx_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  rx_pend_q, rx_pend_d;
  logic [INST_W-1:0]     buf_q, buf_d;
  logic [INST_W-1:0]     inst_q, inst_d;
  logic [ADDR_BUS_W-1:0] inst_pc_q, inst_pc_d;
  logic                  inst_valid_q, inst_valid_d;

  logic              ic_hit;
  logic [INST_W-1:0] ic_rdata;
  logic              ic_wr_en;
  logic              issue_fire;
  logic              fill_done;
  logic [INST_W-1:0] word_asm;

  icache_dm #(
    .ADDR_W   (ADDR_W),
    .IC_LINES (IC_LINES)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .rd_waddr_i (pc_i[ADDR_W-1:2]),
    .rd_hit_o   (ic_hit),
    .rd_data_o  (ic_rdata),
    .wr_en_i    (ic_wr_en),
    .wr_waddr_i (fpc_q[ADDR_W-1:2]),
    .wr_data_i  (word_asm)
  );

  // Byte addresses wrap naturally at ADDR_W bits.
  assign mem_addr_o   = fpc_q[ADDR_W-1:0] + ADDR_W'(issue_cnt_q);
  assign mem_req_o    = mem_req_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;

  assign issue_fire = mem_req_q && mem_grant_i;
  // rx_pend_q marks that a byte was issued last cycle, so mem_data_i carries it now.
  assign word_asm   = place_byte(buf_q, rx_cnt_q, mem_data_i);
  assign fill_done  = (state_q == IF_FETCH) && rx_pend_q && (rx_cnt_q == 2'd3);
  assign ic_wr_en   = fill_done && !branch_i && !rst;

  // The PC is released in the cycle the word lands, unless the word must be parked
  // in HOLD; in HOLD it is released in the cycle the outputs will take the word.
  always_comb begin
    stall_req_o = 1'b0;
    if (!rst && !branch_i) begin
      case (state_q)
        IF_IDLE:  stall_req_o = ce_i && !ic_hit;
        IF_FETCH: stall_req_o = !(fill_done && !id_stall_i);
        IF_HOLD:  stall_req_o = id_stall_i;
        default:  stall_req_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    issue_cnt_d  = issue_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    mem_req_d    = mem_req_q;
    rx_pend_d    = rx_pend_q;
    buf_d        = buf_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    if (branch_i) begin
      // Any byte still in flight is dropped by clearing rx_pend.
      state_d      = IF_IDLE;
      mem_req_d    = 1'b0;
      rx_pend_d    = 1'b0;
      inst_valid_d = 1'b0;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (ce_i && !ic_hit) begin
            state_d     = IF_FETCH;
            fpc_d       = pc_i;
            issue_cnt_d = 2'd0;
            rx_cnt_d    = 2'd0;
            mem_req_d   = 1'b1;
            rx_pend_d   = 1'b0;
            buf_d       = '0;
          end
          if (!id_stall_i) begin
            if (ce_i && ic_hit) begin
              inst_d       = ic_rdata;
              inst_pc_d    = pc_i;
              inst_valid_d = 1'b1;
            end else begin
              inst_valid_d = 1'b0;
            end
          end
        end

        IF_FETCH: begin
          rx_pend_d = issue_fire;
          if (issue_fire) begin
            issue_cnt_d = issue_cnt_q + 2'd1;
            if (issue_cnt_q == 2'd3) mem_req_d = 1'b0;
          end
          if (rx_pend_q) begin
            buf_d    = word_asm;
            rx_cnt_d = rx_cnt_q + 2'd1;
          end
          if (fill_done) begin
            if (id_stall_i) begin
              state_d = IF_HOLD;
            end else begin
              state_d      = IF_IDLE;
              inst_d       = word_asm;
              inst_pc_d    = fpc_q;
              inst_valid_d = 1'b1;
            end
          end else if (!id_stall_i) begin
            inst_valid_d = 1'b0;
          end
        end

        IF_HOLD: begin
          if (!id_stall_i) begin
            state_d      = IF_IDLE;
            inst_d       = buf_q;
            inst_pc_d    = fpc_q;
            inst_valid_d = 1'b1;
          end
        end

        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fpc_q <= fpc_d;
    buf_q <= buf_d;
    if (rst) begin
      state_q      <= IF_IDLE;
      issue_cnt_q  <= 2'd0;
      rx_cnt_q     <= 2'd0;
      mem_req_q    <= 1'b0;
      rx_pend_q    <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      mem_req_q    <= mem_req_d;
      rx_pend_q    <= rx_pend_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

endmodule
